// File: rtl/game_stage_ctrl_if.sv
// game_stage_ctrl_if: bundle of command, direction and object-position inputs
// plus game/player status outputs between keyboard decode, the controller
// and the renderer.
interface game_stage_ctrl_if #(
  parameter int POS_W      = 9,
  parameter int NUM_STAGES = 3
);
  logic                  cmd_valid;
  logic [3:0]            cmd;
  logic [3:0]            dir_held;
  logic [POS_W-1:0]      obj_x;
  logic [POS_W-1:0]      obj_y;
  logic [POS_W-1:0]      boss_x;
  logic [POS_W-1:0]      boss_y;
  logic [2:0]            game_state;
  logic [3:0]            stage;
  logic [NUM_STAGES-1:0] unlocked;
  logic [POS_W-1:0]      player_x;
  logic [POS_W-1:0]      player_y;
  logic [1:0]            player_dir;
  logic [1:0]            anim_frame;
  logic [3:0]            keys_found;
  logic [1:0]            todo;
  logic                  key_pickup;

  modport master (
    output cmd_valid, cmd, dir_held, obj_x, obj_y, boss_x, boss_y,
    input  game_state, stage, unlocked, player_x, player_y, player_dir,
           anim_frame, keys_found, todo, key_pickup
  );

  modport slave (
    input  cmd_valid, cmd, dir_held, obj_x, obj_y, boss_x, boss_y,
    output game_state, stage, unlocked, player_x, player_y, player_dir,
           anim_frame, keys_found, todo, key_pickup
  );
endinterface

// File: rtl/game_stage_ctrl.sv
// game_stage_ctrl: stage FSM (title/play/success/fail/staff), stage unlocking,
// rate-limited clamped player motion, walk animation, key pickup counting and
// door/boss overlap detection. Every output is driven directly by a flop.
module game_stage_ctrl #(
  parameter int POS_W       = 9,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 319,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 239,
  parameter int START_X     = 40,
  parameter int START_Y     = 130,
  parameter int STEP        = 1,
  parameter int MOVE_DIV    = 250000,
  parameter int ANIM_FRAMES = 3,
  parameter int NUM_STAGES  = 3,
  parameter int KEYS_NEEDED = 3,
  parameter int HIT         = 20,
  parameter logic [NUM_STAGES-1:0] BOSS_MASK = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  game_stage_ctrl_if.slave bus
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int EXT_W = POS_W + 1;
  typedef logic [EXT_W-1:0] ext_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MOVE_DIV - 1);
  localparam logic [1:0]       ANIM_LAST = 2'(ANIM_FRAMES - 1);
  localparam logic [3:0]       KEYS_FULL = 4'(KEYS_NEEDED);
  localparam logic [3:0]       LAST_STG  = 4'(NUM_STAGES);
  localparam ext_t             X_LO      = ext_t'(X_MIN);
  localparam ext_t             X_HI      = ext_t'(X_MAX);
  localparam ext_t             Y_LO      = ext_t'(Y_MIN);
  localparam ext_t             Y_HI      = ext_t'(Y_MAX);
  localparam ext_t             STEP_E    = ext_t'(STEP);
  localparam ext_t             HIT_E     = ext_t'(HIT);
  localparam logic [POS_W-1:0] START_XP  = POS_W'(START_X);
  localparam logic [POS_W-1:0] START_YP  = POS_W'(START_Y);
  localparam logic [3:0]       CMD_NEXT  = 4'd8;
  localparam logic [3:0]       CMD_BACK  = 4'd9;
  localparam logic [3:0]       CMD_RETRY = 4'd10;

  typedef enum logic [2:0] {
    ST_TITLE   = 3'd0,
    ST_PLAY    = 3'd1,
    ST_SUCCESS = 3'd2,
    ST_FAIL    = 3'd3,
    ST_STAFF   = 3'd4
  } state_e;

  // Unsigned distance without wrap-around.
  function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  // Box overlap test: both axis distances strictly inside the half-box.
  function automatic logic overlap(input logic [POS_W-1:0] ax, input logic [POS_W-1:0] ay,
                                   input logic [POS_W-1:0] bx, input logic [POS_W-1:0] by);
    overlap = ({1'b0, abs_diff(ax, bx)} < HIT_E) && ({1'b0, abs_diff(ay, by)} < HIT_E);
  endfunction

  // Move towards the lower bound, done one bit wider so it cannot underflow.
  function automatic logic [POS_W-1:0] step_dec(input logic [POS_W-1:0] p, input ext_t lo);
    ext_t pe;
    pe = {1'b0, p};
    if (pe < lo + STEP_E) begin
      step_dec = lo[POS_W-1:0];
    end else begin
      step_dec = POS_W'(pe - STEP_E);
    end
  endfunction

  // Move towards the upper bound, done one bit wider so it cannot overflow.
  function automatic logic [POS_W-1:0] step_inc(input logic [POS_W-1:0] p, input ext_t hi);
    ext_t sum;
    sum = {1'b0, p} + STEP_E;
    if (sum > hi) begin
      step_inc = hi[POS_W-1:0];
    end else begin
      step_inc = sum[POS_W-1:0];
    end
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            stage_q, stage_d;
  logic [NUM_STAGES-1:0] unlocked_q, unlocked_d;
  logic [POS_W-1:0]      x_q, x_d, y_q, y_d;
  logic [1:0]            dir_q, dir_d, anim_q, anim_d, todo_q, todo_d;
  logic [3:0]            keys_q, keys_d;
  logic                  lock_q, lock_d, pickup_q, pickup_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic        obj_ov_s, boss_ov_s, sel_ok_s, door_s, boss_hit_s;
  logic        next_s, back_s, retry_s, enter_play_s, run_s;
  logic [15:0] unl_ext_s, boss_ext_s;

  // Widened copies make command/stage indexing safe for any 4-bit value.
  assign unl_ext_s  = 16'(unlocked_q);
  assign boss_ext_s = 16'(BOSS_MASK);
  assign obj_ov_s   = overlap(x_q, y_q, bus.obj_x, bus.obj_y);
  assign boss_ov_s  = overlap(x_q, y_q, bus.boss_x, bus.boss_y);
  assign next_s     = bus.cmd_valid && (bus.cmd == CMD_NEXT);
  assign back_s     = bus.cmd_valid && (bus.cmd == CMD_BACK);
  assign retry_s    = bus.cmd_valid && (bus.cmd == CMD_RETRY);
  assign sel_ok_s   = bus.cmd_valid && (bus.cmd != 4'd0) && (bus.cmd <= LAST_STG) &&
                      unl_ext_s[bus.cmd - 4'd1];
  assign door_s     = (state_q == ST_PLAY) && (keys_q == KEYS_FULL) && obj_ov_s;
  assign boss_hit_s = (state_q == ST_PLAY) && (stage_q != 4'd0) &&
                      boss_ext_s[stage_q - 4'd1] && boss_ov_s;
  assign enter_play_s = (state_d == ST_PLAY) && (state_q != ST_PLAY);
  assign run_s        = (state_d == ST_PLAY) && (state_q == ST_PLAY);

  // Stage FSM: command handling, door/boss outcome (door wins) and unlocking.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    unlocked_d = unlocked_q;
    case (state_q)
      ST_TITLE: begin
        if (sel_ok_s) begin
          state_d = ST_PLAY;
          stage_d = bus.cmd;
        end else begin
          state_d = ST_TITLE;
        end
      end
      ST_PLAY: begin
        if (door_s) begin
          state_d = ST_SUCCESS;
          if (stage_q < LAST_STG) begin
            unlocked_d = unlocked_q | NUM_STAGES'(16'h0001 << stage_q);
          end else begin
            unlocked_d = unlocked_q;
          end
        end else if (boss_hit_s) begin
          state_d = ST_FAIL;
        end else if (back_s) begin
          state_d = ST_TITLE;
          stage_d = 4'd0;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_SUCCESS: begin
        if (next_s) begin
          if (stage_q == LAST_STG) begin
            state_d = ST_STAFF;
          end else begin
            state_d = ST_PLAY;
            stage_d = stage_q + 4'd1;
          end
        end else if (back_s) begin
          state_d = ST_TITLE;
          stage_d = 4'd0;
        end else begin
          state_d = ST_SUCCESS;
        end
      end
      ST_FAIL: begin
        if (retry_s) begin
          state_d = ST_PLAY;
        end else if (back_s) begin
          state_d = ST_TITLE;
          stage_d = 4'd0;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_STAFF: begin
        if (back_s) begin
          state_d = ST_TITLE;
          stage_d = 4'd0;
        end else begin
          state_d = ST_STAFF;
        end
      end
      default: begin
        state_d = ST_TITLE;
        stage_d = 4'd0;
      end
    endcase
  end

  // Motion: tick divider, direction priority up>left>down>right, clamping, walk frames.
  always_comb begin
    cnt_d  = {CNT_W{1'b0}};
    x_d    = START_XP;
    y_d    = START_YP;
    dir_d  = 2'd3;
    anim_d = 2'd0;
    if (run_s) begin
      x_d    = x_q;
      y_d    = y_q;
      dir_d  = dir_q;
      anim_d = anim_q;
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CNT_W{1'b0}};
        if (bus.dir_held[3]) begin
          dir_d = 2'd0;
          y_d   = step_dec(y_q, Y_LO);
        end else if (bus.dir_held[2]) begin
          dir_d = 2'd1;
          x_d   = step_dec(x_q, X_LO);
        end else if (bus.dir_held[1]) begin
          dir_d = 2'd2;
          y_d   = step_inc(y_q, Y_HI);
        end else if (bus.dir_held[0]) begin
          dir_d = 2'd3;
          x_d   = step_inc(x_q, X_HI);
        end else begin
          dir_d = dir_q;
        end
        if (bus.dir_held == 4'd0) begin
          anim_d = 2'd0;
        end else if (anim_q >= ANIM_LAST) begin
          anim_d = 2'd0;
        end else begin
          anim_d = anim_q + 2'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Keys: one pickup per fresh overlap while a key is wanted; task indicator.
  always_comb begin
    keys_d   = keys_q;
    pickup_d = 1'b0;
    if (enter_play_s) begin
      keys_d = 4'd0;
    end else if ((todo_q == 2'd1) && obj_ov_s && !lock_q) begin
      keys_d   = keys_q + 4'd1;
      pickup_d = 1'b1;
    end else begin
      keys_d = keys_q;
    end
    lock_d = obj_ov_s && (lock_q || pickup_d);
    if (state_d != ST_PLAY) begin
      todo_d = 2'd0;
    end else if (keys_d < KEYS_FULL) begin
      todo_d = 2'd1;
    end else begin
      todo_d = 2'd2;
    end
  end

  // State registers with synchronous active-low reset; progress is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_TITLE;
      stage_q    <= 4'd0;
      unlocked_q <= NUM_STAGES'(1);
      x_q        <= START_XP;
      y_q        <= START_YP;
      dir_q      <= 2'd3;
      anim_q     <= 2'd0;
      keys_q     <= 4'd0;
      todo_q     <= 2'd0;
      lock_q     <= 1'b0;
      pickup_q   <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      unlocked_q <= unlocked_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      anim_q     <= anim_d;
      keys_q     <= keys_d;
      todo_q     <= todo_d;
      lock_q     <= lock_d;
      pickup_q   <= pickup_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.game_state = state_q;
  assign bus.stage      = stage_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.player_x   = x_q;
  assign bus.player_y   = y_q;
  assign bus.player_dir = dir_q;
  assign bus.anim_frame = anim_q;
  assign bus.keys_found = keys_q;
  assign bus.todo       = todo_q;
  assign bus.key_pickup = pickup_q;

endmodule

// File: tb/tb_game_stage_ctrl.sv
// tb_game_stage_ctrl: table vectors, hand-written game sequences and a
// randomized run, all checked against a behavioural game model.
module tb_game_stage_ctrl;
  localparam int POS_W = 9, NS = 3, KN = 3, MD = 4, AF = 3, HIT = 20;
  localparam int SX = 40, SY = 130, XMAX = 319, YMAX = 239, BMASK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_stage_ctrl_if #(.POS_W(POS_W), .NUM_STAGES(NS)) bus ();
  game_stage_ctrl #(.MOVE_DIV(MD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0, n_fail = 0, pick_cnt = 0;
  int m_state, m_stage, m_unl, m_x, m_y, m_dir, m_anim, m_keys, m_todo, m_pick, m_cnt;
  bit m_lock;

  typedef struct {
    bit rst_v; bit cv; int cmd;
    int e_state; int e_stage; int e_unl; int e_x; int e_y; int e_todo;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit near(input int ax, input int ay, input int bx, input int by);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx < HIT) && (dy < HIT);
  endfunction

  task automatic model_reset();
    m_state = 0; m_stage = 0; m_unl = 1; m_x = SX; m_y = SY; m_dir = 3;
    m_anim = 0; m_keys = 0; m_todo = 0; m_pick = 0; m_cnt = 0; m_lock = 1'b0;
  endtask

  // Game rules applied to the inputs present at a rising edge.
  task automatic model_step();
    int ns, nst, c;
    bit ov_o, ov_b, enter, cv;
    if (!rst) begin
      model_reset();
      return;
    end
    ov_o = near(m_x, m_y, int'(bus.obj_x), int'(bus.obj_y));
    ov_b = near(m_x, m_y, int'(bus.boss_x), int'(bus.boss_y));
    cv = bus.cmd_valid; c = int'(bus.cmd);
    ns = m_state; nst = m_stage;
    case (m_state)
      0: if (cv && c >= 1 && c <= NS && m_unl[c-1]) begin ns = 1; nst = c; end
      1: begin
        if (m_keys == KN && ov_o) begin
          ns = 2;
          if (m_stage < NS) m_unl = m_unl | (1 << m_stage);
        end else if (((BMASK >> (m_stage - 1)) & 1) == 1 && ov_b) ns = 3;
        else if (cv && c == 9) begin ns = 0; nst = 0; end
      end
      2: if (cv && c == 8) begin
           if (m_stage == NS) ns = 4;
           else begin ns = 1; nst = m_stage + 1; end
         end else if (cv && c == 9) begin ns = 0; nst = 0; end
      3: if (cv && c == 10) ns = 1;
         else if (cv && c == 9) begin ns = 0; nst = 0; end
      default: if (cv && c == 9) begin ns = 0; nst = 0; end
    endcase
    enter = (ns == 1) && (m_state != 1);
    m_pick = 0;
    if (m_state == 1 && m_keys < KN && ov_o && !m_lock) begin
      m_keys++; m_pick = 1; m_lock = 1'b1;
    end else if (!ov_o) m_lock = 1'b0;
    if (enter) m_keys = 0;
    if (ns != 1 || enter) begin
      m_x = SX; m_y = SY; m_dir = 3; m_anim = 0; m_cnt = 0;
    end else if (m_cnt < MD - 1) m_cnt++;
    else begin
      m_cnt = 0;
      if (bus.dir_held[3]) begin m_dir = 0; m_y = (m_y - 1 < 0) ? 0 : m_y - 1; end
      else if (bus.dir_held[2]) begin m_dir = 1; m_x = (m_x - 1 < 0) ? 0 : m_x - 1; end
      else if (bus.dir_held[1]) begin m_dir = 2; m_y = (m_y + 1 > YMAX) ? YMAX : m_y + 1; end
      else if (bus.dir_held[0]) begin m_dir = 3; m_x = (m_x + 1 > XMAX) ? XMAX : m_x + 1; end
      m_anim = (bus.dir_held != 4'd0) ? (m_anim + 1) % AF : 0;
    end
    m_state = ns; m_stage = nst;
    m_todo = (ns != 1) ? 0 : ((m_keys < KN) ? 1 : 2);
  endtask

  task automatic check_model();
    chk("m_state", 32'(bus.game_state), m_state);
    chk("m_stage", 32'(bus.stage), m_stage);
    chk("m_unlocked", 32'(bus.unlocked), m_unl);
    chk("m_x", 32'(bus.player_x), m_x);
    chk("m_y", 32'(bus.player_y), m_y);
    chk("m_dir", 32'(bus.player_dir), m_dir);
    chk("m_anim", 32'(bus.anim_frame), m_anim);
    chk("m_keys", 32'(bus.keys_found), m_keys);
    chk("m_todo", 32'(bus.todo), m_todo);
    chk("m_pickup", 32'(bus.key_pickup), m_pick);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (bus.key_pickup === 1'b1) pick_cnt++;
    check_model();
  endtask

  task automatic cmd_pulse(input int c);
    bus.cmd_valid = 1'b1; bus.cmd = 4'(c);
    step();
    bus.cmd_valid = 1'b0; bus.cmd = 4'd0;
  endtask

  task automatic obj_at(input int x, input int y);
    bus.obj_x = 9'(x); bus.obj_y = 9'(y);
  endtask

  task automatic boss_at(input int x, input int y);
    bus.boss_x = 9'(x); bus.boss_y = 9'(y);
  endtask

  // Three separate touches of an object placed on the player.
  task automatic collect_keys(input int px, input int py);
    for (int k = 0; k < 3; k++) begin
      obj_at(px, py); step();
      obj_at(300, 10); step();
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  initial begin
    model_reset();
    bus.cmd_valid = 1'b0; bus.cmd = 4'd0; bus.dir_held = 4'd0;
    obj_at(300, 10); boss_at(300, 200);

    vecs[0] = '{1'b0, 1'b0, 0,  0, 0, 1, 40, 130, 0};
    vecs[1] = '{1'b1, 1'b0, 0,  0, 0, 1, 40, 130, 0};
    vecs[2] = '{1'b1, 1'b1, 2,  0, 0, 1, 40, 130, 0};
    vecs[3] = '{1'b1, 1'b1, 11, 0, 0, 1, 40, 130, 0};
    vecs[4] = '{1'b1, 1'b1, 1,  1, 1, 1, 40, 130, 1};
    vecs[5] = '{1'b1, 1'b1, 1,  1, 1, 1, 40, 130, 1};
    vecs[6] = '{1'b1, 1'b1, 9,  0, 0, 1, 40, 130, 0};
    vecs[7] = '{1'b1, 1'b1, 1,  1, 1, 1, 40, 130, 1};
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst_v; bus.cmd_valid = vecs[i].cv; bus.cmd = 4'(vecs[i].cmd);
      step();
      chk("t_state", 32'(bus.game_state), vecs[i].e_state);
      chk("t_stage", 32'(bus.stage), vecs[i].e_stage);
      chk("t_unlocked", 32'(bus.unlocked), vecs[i].e_unl);
      chk("t_x", 32'(bus.player_x), vecs[i].e_x);
      chk("t_y", 32'(bus.player_y), vecs[i].e_y);
      chk("t_todo", 32'(bus.todo), vecs[i].e_todo);
    end
    bus.cmd_valid = 1'b0; bus.cmd = 4'd0;

    // Walk right: one pixel every MD cycles, frames 1,2,0,...
    bus.dir_held = 4'b0001;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i % 4 == 0) chk("walk_anim", 32'(bus.anim_frame), (i / 4) % 3);
    end
    chk("walk_x", 32'(bus.player_x), 50);
    chk("walk_dir", 32'(bus.player_dir), 3);
    bus.dir_held = 4'b0100;
    repeat (300) step();
    chk("clamp_x", 32'(bus.player_x), 0);
    chk("clamp_dir", 32'(bus.player_dir), 1);
    chk("clamp_y", 32'(bus.player_y), 130);
    bus.dir_held = 4'd0;

    // Long overlap yields one key; then two more separate touches.
    pick_cnt = 0;
    obj_at(5, 130);
    repeat (100) step();
    chk("hold_keys", 32'(bus.keys_found), 1);
    chk("hold_pulses", 32'(pick_cnt), 1);
    for (int k = 0; k < 2; k++) begin
      obj_at(300, 10); step(); step();
      obj_at(5, 130); step();
      obj_at(300, 10); step();
    end
    chk("three_keys", 32'(bus.keys_found), 3);
    chk("three_todo", 32'(bus.todo), 2);
    chk("three_pulses", 32'(pick_cnt), 3);

    // Door opens with all keys, next stage starts fresh.
    obj_at(5, 130); step();
    chk("door_state", 32'(bus.game_state), 2);
    chk("door_unlock", 32'(bus.unlocked), 3);
    obj_at(300, 10);
    cmd_pulse(8);
    chk("next_state", 32'(bus.game_state), 1);
    chk("next_stage", 32'(bus.stage), 2);
    chk("next_keys", 32'(bus.keys_found), 0);

    // Clear stage 2, then boss, retry and door+boss tie in stage 3.
    collect_keys(40, 130);
    obj_at(40, 130); step(); obj_at(300, 10);
    chk("s2_unlock", 32'(bus.unlocked), 7);
    cmd_pulse(8);
    chk("s3_stage", 32'(bus.stage), 3);
    boss_at(45, 125); step(); boss_at(300, 200);
    chk("boss_fail", 32'(bus.game_state), 3);
    cmd_pulse(10);
    chk("retry_state", 32'(bus.game_state), 1);
    chk("retry_stage", 32'(bus.stage), 3);
    collect_keys(40, 130);
    obj_at(40, 130); boss_at(45, 125); step();
    obj_at(300, 10); boss_at(300, 200);
    chk("tie_success", 32'(bus.game_state), 2);
    cmd_pulse(8);
    chk("staff_state", 32'(bus.game_state), 4);
    cmd_pulse(9);
    chk("staff_back", 32'(bus.game_state), 0);
    chk("staff_stage", 32'(bus.stage), 0);

    // Reset while playing stage 2 drops all progress.
    cmd_pulse(2);
    chk("pre_rst_stage", 32'(bus.stage), 2);
    bus.dir_held = 4'b0001; repeat (8) step();
    chk("pre_rst_x", 32'(bus.player_x), 42);
    rst = 1'b0; step(); rst = 1'b1; bus.dir_held = 4'd0;
    chk("rst_state", 32'(bus.game_state), 0);
    chk("rst_unlock", 32'(bus.unlocked), 1);
    chk("rst_x", 32'(bus.player_x), 40);
    chk("rst_keys", 32'(bus.keys_found), 0);
    cmd_pulse(2);
    chk("rst_locked", 32'(bus.game_state), 0);

    // Random play with objects frequently placed near the player.
    for (int c = 0; c < 4000; c++) begin
      int sel;
      rst = ($urandom_range(0, 799) != 0);
      bus.cmd_valid = ($urandom_range(0, 5) == 0);
      sel = int'($urandom_range(0, 7));
      bus.cmd = (sel < 6) ? 4'(sel + (sel > 2 ? 5 : 1)) : 4'($urandom_range(0, 15));
      bus.dir_held = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        obj_at(clampi(m_x + int'($urandom_range(0, 50)) - 25, 0, XMAX),
               clampi(m_y + int'($urandom_range(0, 50)) - 25, 0, YMAX));
      else
        obj_at(int'($urandom_range(0, XMAX)), int'($urandom_range(0, YMAX)));
      if ($urandom_range(0, 5) == 0)
        boss_at(clampi(m_x + int'($urandom_range(0, 50)) - 25, 0, XMAX),
                clampi(m_y + int'($urandom_range(0, 50)) - 25, 0, YMAX));
      else
        boss_at(int'($urandom_range(0, XMAX)), int'($urandom_range(0, YMAX)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
